mem_port_arbiter: RTL

// - Shares one single-port memory bus between the fetch stage (instruction reads) and the

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-port memory bus
//
// Purpose: shares one single-port memory bus between instruction fetch and the
// memory-access stage. Each grant drives a registered mem_req/ack transfer.
// Completion returns a one-cycle *_valid pulse with the read data. A transfer that
// waits too long for mem_ack is aborted and flagged on err.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   if_req/if_addr               fetch read request and address
//   if_rdata/if_valid/if_stall   fetch response data, completion pulse, hold line
//   dm_req/dm_we/dm_addr         data request, store flag, address
//   dm_wdata/dm_be               store data and byte enables
//   dm_rdata/dm_valid/dm_stall   data response data, completion pulse, hold line
//   flush                        redirect: kills an in-flight or newly offered fetch
//   mem_req/mem_we/mem_addr      memory bus request, write strobe, address
//   mem_wdata/mem_be             memory bus write data and byte enables
//   mem_ack/mem_rdata            memory bus completion and read data
//   err                          one-cycle pulse on a timeout abort

module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int FAIR_LIMIT     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                dm_stall,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t            state;
  logic [FAIR_W-1:0] fairCnt;
  logic [7:0]        waitCnt;
  logic              kill;

  logic fairHit;
  logic grantIf;
  logic grantDm;
  logic finish;

  // Data normally wins. Fetch wins once data has taken FAIR_LIMIT grants in a row
  // while fetch waited. A flush blocks fetch grants because that fetch would be dead.
  always_comb begin
    fairHit = (fairCnt == FAIR_W'(FAIR_LIMIT));
    grantIf = 1'b0;
    grantDm = 1'b0;
    if (state == IDLE) begin
      grantIf = if_req & ~flush & (~dm_req | fairHit);
      grantDm = dm_req & ~grantIf;
    end
    // Ack takes priority; otherwise abort on the last allowed wait cycle, so
    // mem_req is seen high for exactly TIMEOUT_CYCLES cycles.
    finish = mem_ack | (waitCnt == 8'(TIMEOUT_CYCLES - 1));
  end

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fairCnt   <= '0;
      waitCnt   <= '0;
      kill      <= 1'b0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      err      <= 1'b0;

      if (!if_req || grantIf) begin
        fairCnt <= '0;
      end else if (grantDm && !fairHit) begin
        fairCnt <= fairCnt + FAIR_W'(1);
      end

      case (state)
        IDLE: begin
          kill    <= 1'b0;
          waitCnt <= '0;
          if (grantIf) begin
            state     <= IF_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
          end else if (grantDm) begin
            state     <= DM_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_we ? dm_wdata : '0;
            mem_be    <= dm_we ? dm_be : '1;
          end
        end

        IF_BUSY, DM_BUSY: begin
          if (state == IF_BUSY && flush) begin
            kill <= 1'b1;
          end
          if (finish) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            kill    <= 1'b0;
            err     <= ~mem_ack;
            if (state == IF_BUSY) begin
              // A flush arriving in the completion cycle kills the fetch as well.
              if (!(kill || flush)) begin
                if_valid <= 1'b1;
                if_rdata <= mem_ack ? mem_rdata : '0;
              end
            end else begin
              dm_valid <= 1'b1;
              dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
